// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC from decode redirects
// and loads the IF_ID register (redirects insert a nop bubble).
module if_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
   parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
   parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        PC_IF_ID_Write,
   input  logic        Z,
   input  logic        J,
   input  logic        JR,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   input  logic        interrupt,
   input  logic        exception,
   output logic [63:0] IF_ID,
   output logic [31:0] PC
);

   logic [31:0] r_pc;
   logic [63:0] r_if_id;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;
   logic        w_redirect;
   logic        w_hold;

   // Bit 31 is the kernel-mode flag; only the low 31 bits wrap on increment.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

   assign w_pc_plus4 = pc_inc(r_pc);

   // Next-PC selection; interrupt/exception outrank a load-use stall.
   always_comb begin
      w_next_pc  = w_pc_plus4;
      w_redirect = 1'b0;
      w_hold     = 1'b0;
      if (interrupt) begin
         w_next_pc  = IRQ_VECTOR;
         w_redirect = 1'b1;
      end else if (exception) begin
         w_next_pc  = EXC_VECTOR;
         w_redirect = 1'b1;
      end else if (!PC_IF_ID_Write) begin
         w_next_pc  = r_pc;
         w_hold     = 1'b1;
      end else if (JR) begin
         w_next_pc  = jr_target;
         w_redirect = 1'b1;
      end else if (J) begin
         w_next_pc  = jump_target;
         w_redirect = 1'b1;
      end else if (Z) begin
         w_next_pc  = branch_target;
         w_redirect = 1'b1;
      end else begin
         w_next_pc  = w_pc_plus4;
         w_redirect = 1'b0;
      end
   end

   // PC and IF_ID registers; a bubble reports the redirect target as its own PC+4 base.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc    <= RESET_VECTOR;
         r_if_id <= 64'h0;
      end else if (w_hold) begin
         r_pc    <= r_pc;
         r_if_id <= r_if_id;
      end else if (w_redirect) begin
         r_pc    <= w_next_pc;
         r_if_id <= {pc_inc(w_next_pc), 32'h0000_0000};
      end else begin
         r_pc    <= w_next_pc;
         r_if_id <= {w_pc_plus4, imem_data};
      end
   end

   assign imem_addr = r_pc;
   assign PC        = r_pc;
   assign IF_ID     = r_if_id;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the ROM returns its own address as the instruction word.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        PC_IF_ID_Write;
   logic        Z, J, JR;
   logic [31:0] branch_target, jump_target, jr_target;
   logic        interrupt, exception;
   logic [63:0] IF_ID;
   logic [31:0] PC;

   int n_checks = 0;
   int n_errors = 0;

   if_stage dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .PC_IF_ID_Write(PC_IF_ID_Write), .Z(Z), .J(J), .JR(JR),
      .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
      .interrupt(interrupt), .exception(exception), .IF_ID(IF_ID), .PC(PC)
   );

   always #5 clk = ~clk;
   assign imem_data = imem_addr;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      PC_IF_ID_Write = 1'b1;
      Z = 1'b0; J = 1'b0; JR = 1'b0;
      interrupt = 1'b0; exception = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
   endtask

   task automatic jr_to(input logic [31:0] tgt);
      JR = 1'b1; jr_target = tgt;
      step();
      JR = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step(); step();
      n_checks++;
      if (PC !== 32'h8000_0000) begin n_errors++; $display("FAIL reset_pc got %h exp %h", PC, 32'h8000_0000); end
      n_checks++;
      if (IF_ID !== 64'h0) begin n_errors++; $display("FAIL reset_ifid got %h exp %h", IF_ID, 64'h0); end
      n_checks++;
      if (imem_addr !== 32'h8000_0000) begin n_errors++; $display("FAIL reset_imem got %h exp %h", imem_addr, 32'h8000_0000); end
      rst_n = 1'b1;
   endtask

   task automatic test_free_run();
      step();
      n_checks++;
      if (PC !== 32'h8000_0004) begin n_errors++; $display("FAIL run1_pc got %h exp %h", PC, 32'h8000_0004); end
      n_checks++;
      if (IF_ID !== 64'h8000_0004_8000_0000) begin n_errors++; $display("FAIL run1_ifid got %h exp %h", IF_ID, 64'h8000_0004_8000_0000); end
      step();
      n_checks++;
      if (PC !== 32'h8000_0008) begin n_errors++; $display("FAIL run2_pc got %h exp %h", PC, 32'h8000_0008); end
      step();
      n_checks++;
      if (PC !== 32'h8000_000C) begin n_errors++; $display("FAIL run3_pc got %h exp %h", PC, 32'h8000_000C); end
      n_checks++;
      if (IF_ID !== 64'h8000_000C_8000_0008) begin n_errors++; $display("FAIL run3_ifid got %h exp %h", IF_ID, 64'h8000_000C_8000_0008); end
   endtask

   task automatic test_stall();
      jr_to(32'h0000_0010);
      n_checks++;
      if (IF_ID !== 64'h0000_0014_0000_0000) begin n_errors++; $display("FAIL jr10_ifid got %h exp %h", IF_ID, 64'h0000_0014_0000_0000); end
      PC_IF_ID_Write = 1'b0; Z = 1'b1; branch_target = 32'h0000_0040;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (PC !== 32'h0000_0010) begin n_errors++; $display("FAIL stall_pc got %h exp %h", PC, 32'h0000_0010); end
         n_checks++;
         if (IF_ID !== 64'h0000_0014_0000_0000) begin n_errors++; $display("FAIL stall_ifid got %h exp %h", IF_ID, 64'h0000_0014_0000_0000); end
      end
      PC_IF_ID_Write = 1'b1; Z = 1'b0;
      step();
      n_checks++;
      if (PC !== 32'h0000_0014) begin n_errors++; $display("FAIL release_pc got %h exp %h", PC, 32'h0000_0014); end
      n_checks++;
      if (IF_ID !== 64'h0000_0014_0000_0010) begin n_errors++; $display("FAIL release_ifid got %h exp %h", IF_ID, 64'h0000_0014_0000_0010); end
   endtask

   task automatic test_branch();
      step(); step(); step();
      n_checks++;
      if (PC !== 32'h0000_0020) begin n_errors++; $display("FAIL pre_branch_pc got %h exp %h", PC, 32'h0000_0020); end
      Z = 1'b1; branch_target = 32'h0000_0040;
      step();
      Z = 1'b0;
      n_checks++;
      if (PC !== 32'h0000_0040) begin n_errors++; $display("FAIL branch_pc got %h exp %h", PC, 32'h0000_0040); end
      n_checks++;
      if (IF_ID !== 64'h0000_0044_0000_0000) begin n_errors++; $display("FAIL branch_ifid got %h exp %h", IF_ID, 64'h0000_0044_0000_0000); end
      step();
      n_checks++;
      if (IF_ID !== 64'h0000_0044_0000_0040) begin n_errors++; $display("FAIL branch_next_ifid got %h exp %h", IF_ID, 64'h0000_0044_0000_0040); end
   endtask

   task automatic test_jump();
      J = 1'b1; jump_target = 32'h0000_0300;
      step();
      J = 1'b0;
      n_checks++;
      if (PC !== 32'h0000_0300) begin n_errors++; $display("FAIL j_pc got %h exp %h", PC, 32'h0000_0300); end
      n_checks++;
      if (IF_ID !== 64'h0000_0304_0000_0000) begin n_errors++; $display("FAIL j_ifid got %h exp %h", IF_ID, 64'h0000_0304_0000_0000); end
      // JR outranks J and Z when decode asserts several.
      JR = 1'b1; J = 1'b1; Z = 1'b1;
      jr_target = 32'h0000_0500; jump_target = 32'h0000_0600; branch_target = 32'h0000_0700;
      step();
      JR = 1'b0; J = 1'b0; Z = 1'b0;
      n_checks++;
      if (PC !== 32'h0000_0500) begin n_errors++; $display("FAIL prio_pc got %h exp %h", PC, 32'h0000_0500); end
      J = 1'b1; Z = 1'b1;
      step();
      J = 1'b0; Z = 1'b0;
      n_checks++;
      if (PC !== 32'h0000_0600) begin n_errors++; $display("FAIL j_over_z_pc got %h exp %h", PC, 32'h0000_0600); end
   endtask

   task automatic test_jr_user();
      jr_to(32'h8000_0200);
      jr_to(32'h0000_0100);
      n_checks++;
      if (PC !== 32'h0000_0100) begin n_errors++; $display("FAIL jr_user_pc got %h exp %h", PC, 32'h0000_0100); end
      n_checks++;
      if (IF_ID !== 64'h0000_0104_0000_0000) begin n_errors++; $display("FAIL jr_user_ifid got %h exp %h", IF_ID, 64'h0000_0104_0000_0000); end
      step();
      n_checks++;
      if (PC !== 32'h0000_0104) begin n_errors++; $display("FAIL jr_user_inc got %h exp %h", PC, 32'h0000_0104); end
   endtask

   task automatic test_irq_exc();
      interrupt = 1'b1; exception = 1'b1; PC_IF_ID_Write = 1'b0;
      step();
      interrupt = 1'b0; exception = 1'b0; PC_IF_ID_Write = 1'b1;
      n_checks++;
      if (PC !== 32'h8000_0004) begin n_errors++; $display("FAIL irq_pc got %h exp %h", PC, 32'h8000_0004); end
      n_checks++;
      if (IF_ID !== 64'h8000_0008_0000_0000) begin n_errors++; $display("FAIL irq_ifid got %h exp %h", IF_ID, 64'h8000_0008_0000_0000); end
      exception = 1'b1; PC_IF_ID_Write = 1'b0; JR = 1'b1; jr_target = 32'h0000_0100;
      step();
      exception = 1'b0; PC_IF_ID_Write = 1'b1; JR = 1'b0;
      n_checks++;
      if (PC !== 32'h8000_0008) begin n_errors++; $display("FAIL exc_pc got %h exp %h", PC, 32'h8000_0008); end
      n_checks++;
      if (IF_ID !== 64'h8000_000C_0000_0000) begin n_errors++; $display("FAIL exc_ifid got %h exp %h", IF_ID, 64'h8000_000C_0000_0000); end
   endtask

   task automatic test_wrap();
      jr_to(32'h7FFF_FFFC);
      n_checks++;
      if (IF_ID !== 64'h0000_0000_0000_0000) begin n_errors++; $display("FAIL wrap_lo_bubble got %h exp %h", IF_ID, 64'h0); end
      step();
      n_checks++;
      if (PC !== 32'h0000_0000) begin n_errors++; $display("FAIL wrap_lo_pc got %h exp %h", PC, 32'h0000_0000); end
      n_checks++;
      if (IF_ID !== 64'h0000_0000_7FFF_FFFC) begin n_errors++; $display("FAIL wrap_lo_ifid got %h exp %h", IF_ID, 64'h0000_0000_7FFF_FFFC); end
      jr_to(32'hFFFF_FFFC);
      step();
      n_checks++;
      if (PC !== 32'h8000_0000) begin n_errors++; $display("FAIL wrap_hi_pc got %h exp %h", PC, 32'h8000_0000); end
      n_checks++;
      if (IF_ID !== 64'h8000_0000_FFFF_FFFC) begin n_errors++; $display("FAIL wrap_hi_ifid got %h exp %h", IF_ID, 64'h8000_0000_FFFF_FFFC); end
   endtask

   task automatic test_reset_midflush();
      Z = 1'b1; branch_target = 32'h0000_0040; rst_n = 1'b0;
      step();
      Z = 1'b0; rst_n = 1'b1;
      n_checks++;
      if (PC !== 32'h8000_0000) begin n_errors++; $display("FAIL rst_flush_pc got %h exp %h", PC, 32'h8000_0000); end
      n_checks++;
      if (IF_ID !== 64'h0) begin n_errors++; $display("FAIL rst_flush_ifid got %h exp %h", IF_ID, 64'h0); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_branch();
      test_jump();
      test_jr_user();
      test_irq_exc();
      test_wrap();
      test_reset_midflush();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipelined CPU, sitting directly upstream of the decode stage. Holds the program counter, drives the instruction-memory address, selects the next PC from the decode-stage redirect signals (branch, jump, jump-register, interrupt, exception), and loads the 64-bit IF_ID pipeline register consumed by decode. Decode resolves branches, so taken redirects squash exactly one fetched instruction; there is no delay slot.

## Interface
Parameters:
- RESET_VECTOR, 32'h8000_0000, PC after reset (kernel mode, bit 31 set)
- IRQ_VECTOR, 32'h8000_0004, interrupt handler entry
- EXC_VECTOR, 32'h8000_0008, undefined-instruction handler entry

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- imem_addr  output  32  current PC to instruction ROM (combinational read)
- imem_data  input  32  instruction word at imem_addr, same cycle
- PC_IF_ID_Write  input  1  0 = load-use stall: hold PC and IF_ID
- Z  input  1  branch in decode is taken
- J  input  1  decode holds j/jal
- JR  input  1  decode holds jr/jalr
- branch_target  input  32  taken-branch address
- jump_target  input  32  j/jal address
- jr_target  input  32  register jump address (may clear bit 31)
- interrupt  input  1  decode accepts an interrupt this cycle
- exception  input  1  decode flags undefined instruction this cycle
- IF_ID  output  64  [31:0] instruction, [63:32] PC+4
- PC  output  32  current PC register, for debug

## Operation
- pc_plus4 = {PC[31], PC[30:0] + 31'd4}: 31-bit wrap, bit 31 (kernel flag) never changes through increment.
- Next-PC priority, highest first:
  1. interrupt -> IRQ_VECTOR, redirect
  2. exception -> EXC_VECTOR, redirect
  3. PC_IF_ID_Write == 0 -> PC held, IF_ID held, Z/J/JR ignored
  4. JR -> jr_target, redirect
  5. J -> jump_target, redirect
  6. Z -> branch_target, redirect
  7. otherwise -> pc_plus4, normal
- Normal: IF_ID <= {pc_plus4, imem_data}.
- Redirect (flush): IF_ID[31:0] <= 32'h0000_0000 (sll $0 nop); IF_ID[63:32] <= next_pc + 4 with same bit-31 rule. A bubble in decode therefore reports the redirect target as its own address, so an interrupt taken on the bubble returns to the target.
- interrupt and exception override a stall: the stalled decode instruction is abandoned (decode saves its return address into $k0).
- jr_target written unchanged, including bit 31; jr $k0 is the only way back to user mode.
- imem_addr = PC combinationally; no memory handshake.
- Z, J, JR assumed mutually exclusive from decode; if not, priority above still applies.

## Timing
- Reset (rst_n low at rising edge): PC <= RESET_VECTOR, IF_ID <= 64'h0. Outputs valid one cycle after the first edge with rst_n high no sooner; reset mid-flush discards the redirect.
- Fetch latency: instruction at PC appears in IF_ID on the next rising edge.
- Redirect penalty: one cycle; instruction fetched in the redirect cycle never reaches IF_ID.
- Stall: every cycle with PC_IF_ID_Write == 0 and no interrupt/exception, PC and IF_ID hold bit-exact; release resumes with same PC.
- Interrupt and exception the same cycle: interrupt wins, EXC_VECTOR not used.
- PC = 32'h7FFF_FFFC increments to 32'h0000_0000; 32'hFFFF_FFFC increments to 32'h8000_0000.

## Test plan
- Reset then 3 free-run cycles, ROM word = address -> PC 8000_0000, 8000_0004, 8000_0008, 8000_000C; IF_ID = {8000_0004, 8000_0000} after first edge.
- PC_IF_ID_Write low 2 cycles at PC 0000_0010 with Z = 1 -> PC stays 0000_0010, IF_ID unchanged, branch ignored; release -> PC 0000_0014.
- Z = 1, branch_target 0000_0040 at PC 0000_0020 -> PC 0000_0040, IF_ID = {0000_0044, 0000_0000}; next cycle IF_ID holds word at 0000_0040.
- JR = 1, jr_target 0000_0100 at PC 8000_0200 -> PC 0000_0100 (user mode), next increment 0000_0104.
- interrupt = 1, exception = 1, PC_IF_ID_Write = 0 same cycle -> PC 8000_0004, IF_ID = {8000_0008, 0000_0000}.
- PC preset via jr to 7FFF_FFFC, free run -> 0000_0000; via jr to FFFF_FFFC -> 8000_0000.
